// File: rtl/q2_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : q2_sequencer
// Purpose  : Instruction sequencer for the Q2 CPU. It holds the machine-state
//            bits s0-s3, the write-strobe phase ws, the opcode/deref
//            instruction latch and the carry flag. True and complement forms
//            of these feed the control decode stage. That stage returns
//            wrf/fout, which update the flag.
// Option   : `define Q2_SINGLE_STEP_EN adds the step port. A rising edge on
//            step, seen while stopped with run=0, executes exactly one
//            instruction.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            run                 - run switch (level)
//            step                - single-step pulse (Q2_SINGLE_STEP_EN only)
//            dbus[7:0]           - data bus; opcode=dbus[6:4], deref=dbus[3]
//            wrf, fout           - flag write enable / new flag value
//            s0..s3, ns0..ns3    - state bits and complements
//            ws                  - 0 = phase A (read), 1 = phase B (write)
//            o0..o2, no0..no2    - latched opcode and complements
//            deref               - latched indirect bit
//            nf                  - inverted carry flag
//            running             - instruction in progress
// Revision : 1.0 - initial release
// ============================================================================
module q2_sequencer #(
  parameter int         ALU_STEPS = 3,
  parameter logic [2:0] SHIFT_OP  = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
`ifdef Q2_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] dbus,
  input  logic       wrf,
  input  logic       fout,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       ns0,
  output logic       ns1,
  output logic       ns2,
  output logic       ns3,
  output logic       ws,
  output logic       o0,
  output logic       o1,
  output logic       o2,
  output logic       no0,
  output logic       no1,
  output logic       no2,
  output logic       deref,
  output logic       nf,
  output logic       running
);

  // The encoding equals {s3,s2,s1,s0}, so the state register drives the
  // state outputs directly.
  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_DEREF = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_EXEC  = 4'b0011,
    ST_ALU1  = 4'b0100,
    ST_ALU2  = 4'b1000,
    ST_ALU3  = 4'b1100
  } state_e;

  state_e     state_q, state_d;
  logic       ws_q, ws_d;
  logic [2:0] op_q, op_d;
  logic       deref_q, deref_d;
  logic       f_q, f_d;
  logic       active_q, active_d;
  logic       start;

  // Only the opcode and deref fields of the bus are used.
  logic       unused_dbus;
  assign unused_dbus = ^{dbus[7], dbus[2:0]};

`ifdef Q2_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  // A step edge starts execution only while stopped. When run is also
  // high, run takes over and execution continues.
  assign start = run | (~active_q & step & ~step_q);
`else
  assign start = run;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ws_q     <= 1'b0;
      op_q     <= 3'b000;
      deref_q  <= 1'b0;
      f_q      <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ws_q     <= ws_d;
      op_q     <= op_d;
      deref_q  <= deref_d;
      f_q      <= f_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ws_d     = ws_q;
    op_d     = op_q;
    deref_d  = deref_q;
    f_d      = f_q;
    active_d = active_q;

    if (!ws_q) begin
      // Phase A. FETCH phase A is the instruction boundary. The decision to
      // continue or stop is made here; the sequencer idles here when
      // stopped.
      if (state_q == ST_FETCH) begin
        active_d = start;
        ws_d     = start;
      end else begin
        ws_d = 1'b1;
      end
    end else begin
      // Phase B ends: this is the step edge.
      ws_d = 1'b0;
      if (wrf) f_d = fout;

      case (state_q)
        ST_FETCH: begin
          // Route on the fields being latched at this same edge.
          op_d    = dbus[6:4];
          deref_d = dbus[3];
          if (dbus[3])      state_d = ST_DEREF;
          else if (dbus[6]) state_d = ST_LOAD;
          else              state_d = ST_EXEC;
        end
        ST_DEREF: state_d = op_q[2] ? ST_LOAD : ST_EXEC;
        ST_LOAD:  state_d = ST_EXEC;
        ST_EXEC:  state_d = (op_q == SHIFT_OP) ? ST_ALU1 : ST_FETCH;
        ST_ALU1:  state_d = (ALU_STEPS > 1) ? ST_ALU2 : ST_FETCH;
        ST_ALU2:  state_d = (ALU_STEPS > 2) ? ST_ALU3 : ST_FETCH;
        ST_ALU3:  state_d = ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  assign {s3, s2, s1, s0}     = state_q;
  assign {ns3, ns2, ns1, ns0} = ~state_q;
  assign ws                   = ws_q;
  assign {o2, o1, o0}         = op_q;
  assign {no2, no1, no0}      = ~op_q;
  assign deref                = deref_q;
  assign nf                   = ~f_q;
  assign running              = active_q;

endmodule
`default_nettype wire

// File: tb/tb_q2_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_q2_sequencer
// Purpose  : Directed self-checking bench for q2_sequencer in the default
//            build, with ALU_STEPS=3 and SHIFT_OP=110.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q2_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
`ifdef Q2_SINGLE_STEP_EN
  logic       step;
`endif
  logic [7:0] dbus;
  logic       wrf;
  logic       fout;
  logic       s0, s1, s2, s3, ns0, ns1, ns2, ns3;
  logic       ws, o0, o1, o2, no0, no1, no2, deref, nf, running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q2_sequencer #(.ALU_STEPS(3), .SHIFT_OP(3'b110)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
`ifdef Q2_SINGLE_STEP_EN
    .step    (step),
`endif
    .dbus    (dbus),
    .wrf     (wrf),
    .fout    (fout),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .ns0     (ns0),
    .ns1     (ns1),
    .ns2     (ns2),
    .ns3     (ns3),
    .ws      (ws),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .no0     (no0),
    .no1     (no1),
    .no2     (no2),
    .deref   (deref),
    .nf      (nf),
    .running (running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_s, input logic e_ws,
                         input logic [2:0] e_o, input logic e_deref,
                         input logic e_nf, input logic e_run);
    logic [3:0] e_ns;
    logic [2:0] e_no;
    e_ns = ~e_s;
    e_no = ~e_o;
    chk({tag, "_s"},     {4'h0, s3, s2, s1, s0},     {4'h0, e_s});
    chk({tag, "_ns"},    {4'h0, ns3, ns2, ns1, ns0}, {4'h0, e_ns});
    chk({tag, "_ws"},    {7'h0, ws},                 {7'h0, e_ws});
    chk({tag, "_o"},     {5'h0, o2, o1, o0},         {5'h0, e_o});
    chk({tag, "_no"},    {5'h0, no2, no1, no0},      {5'h0, e_no});
    chk({tag, "_deref"}, {7'h0, deref},              {7'h0, e_deref});
    chk({tag, "_nf"},    {7'h0, nf},                 {7'h0, e_nf});
    chk({tag, "_run"},   {7'h0, running},            {7'h0, e_run});
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dbus = 8'h00; wrf = 1'b0; fout = 1'b0;
`ifdef Q2_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    chk_all("reset0", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

    // Plain EXEC instruction: 4 clocks.
    run = 1'b1;
    tick(); chk_all("p_fetchB", 4'b0000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("p_execA",  4'b0011, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("p_execB",  4'b0011, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("p_fetchA", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    // Opcode 100 with deref: FETCH, DEREF, LOAD, EXEC = 8 clocks.
    tick(); chk_all("d_fetchB", 4'b0000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    dbus = 8'h48;
    tick(); chk_all("d_derefA", 4'b0001, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1);
    dbus = 8'h00;
    tick(); chk_all("d_derefB", 4'b0001, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("d_loadA",  4'b0010, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("d_loadB",  4'b0010, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("d_execA",  4'b0011, 1'b0, 3'b100, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("d_execB",  4'b0011, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1);
    wrf = 1'b1; fout = 1'b1;
    tick(); chk_all("d_fetchA", 4'b0000, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1);

    // A flag write during phase A is ignored.
    wrf = 1'b1; fout = 1'b0;
    tick(); chk_all("w_fetchB", 4'b0000, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1);
    wrf = 1'b0; dbus = 8'h60;

    // Shift opcode 110: FETCH, LOAD, EXEC, ALU1..3 = 12 clocks.
    tick(); chk_all("sh_loadA", 4'b0010, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_loadB", 4'b0010, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_execA", 4'b0011, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_execB", 4'b0011, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    wrf = 1'b1; fout = 1'b0;
    tick(); chk_all("sh_alu1A", 4'b0100, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1);
    wrf = 1'b0;
    tick(); chk_all("sh_alu1B", 4'b0100, 1'b1, 3'b110, 1'b0, 1'b1, 1'b1);
    wrf = 1'b1; fout = 1'b1;
    tick(); chk_all("sh_alu2A", 4'b1000, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);
    wrf = 1'b0;
    tick(); chk_all("sh_alu2B", 4'b1000, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_alu3A", 4'b1100, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_alu3B", 4'b1100, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("sh_fetchA", 4'b0000, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1);

    // Reset in DEREF phase B with f=1 overrides run and wrf.
    dbus = 8'h48;
    tick(); chk_all("r_fetchB", 4'b0000, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("r_derefA", 4'b0001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("r_derefB", 4'b0001, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; wrf = 1'b1; fout = 1'b1;
    tick(); chk_all("r_reset", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    rst = 1'b0; wrf = 1'b0; fout = 1'b0;

    // Run dropped during LOAD: the instruction completes, then the
    // sequencer idles.
    dbus = 8'h40;
    tick(); chk_all("s_fetchB", 4'b0000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("s_loadA",  4'b0010, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1);
    run = 1'b0;
    tick(); chk_all("s_loadB",  4'b0010, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("s_execA",  4'b0011, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("s_execB",  4'b0011, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("s_fetchA", 4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("s_idle",   4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("s_idle2",  4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
